// File: rtl/key_entry_buffer_pkg.sv
// Shared definitions for the lock code entry path: key codes, digit
// geometry, FSM state encoding and the code packing helper.
package lock_pkg;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
    localparam logic [3:0] KEY_BKSP      = 4'hA;
    localparam logic [3:0] KEY_ENTER     = 4'hB;
    localparam logic [3:0] KEY_CLR       = 4'hC;
    localparam logic [3:0] DIGIT_BLANK   = 4'hF;

    localparam int         NUM_DIGITS_INT = 6;
    localparam logic [2:0] NUM_DIGITS     = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTRY   = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    // Element 0 is the first entered digit (out1).
    typedef logic [NUM_DIGITS_INT-1:0][3:0] digit_vec_t;

    // All positions blank.
    function automatic digit_vec_t blank_digits();
        digit_vec_t d;
        for (int i = 0; i < NUM_DIGITS_INT; i++) begin
            d[i] = DIGIT_BLANK;
        end
        return d;
    endfunction

    // Pack digits so the first entered digit lands in the top nibble.
    function automatic logic [23:0] pack_code(input digit_vec_t d);
        logic [23:0] c;
        c = 24'h000000;
        for (int i = 0; i < NUM_DIGITS_INT; i++) begin
            c[23-4*i -: 4] = d[i];
        end
        return c;
    endfunction

endpackage

// File: rtl/key_entry_buffer_if.sv
// Keypad event input and code output handshakes of the entry buffer.
interface key_entry_buffer_if;

    logic        key_valid;
    logic        key_ready;
    logic [3:0]  key_code;
    logic        code_valid;
    logic        code_ready;
    logic [23:0] code_data;

    // Driver side: keypad scanner and code comparator.
    modport master (
        output key_valid, key_code, code_ready,
        input  key_ready, code_valid, code_data
    );

    // Entry buffer side.
    modport slave (
        input  key_valid, key_code, code_ready,
        output key_ready, code_valid, code_data
    );

endinterface

// File: rtl/key_entry_buffer_timer.sv
// Inactivity timer for code entry: counts enabled cycles, clears on demand,
// flags the cycle on which the final count is reached.
module entry_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
    parameter int          TO_W           = 29
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i & (cnt_q == LAST);

endmodule

// File: rtl/key_entry_buffer.sv
// Six-digit code entry buffer: collects keypad digits, supports backspace
// and clear, and offers the packed code to the comparator on enter.
module key_entry_buffer
    import lock_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    key_entry_buffer_if.slave     bus,
    output logic [3:0]            out1,
    output logic [3:0]            out2,
    output logic [3:0]            out3,
    output logic [3:0]            out4,
    output logic [3:0]            out5,
    output logic [3:0]            out6,
    output logic [2:0]            digit_count,
    output logic                  entry_err,
    output logic                  timeout
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    digit_vec_t  digits_q, digits_d;
    logic [2:0]  count_q, count_d;
    logic        code_valid_q, code_valid_d;
    logic [23:0] code_data_q, code_data_d;
    logic        key_ready_q, key_ready_d;
    logic        entry_err_q, entry_err_d;
    logic        timeout_q, timeout_d;

    logic        key_acc_s;
    logic        timer_exp_s;
    logic        timer_clr_s;
    logic        timer_en_s;

    assign key_acc_s   = bus.key_valid & key_ready_q;
    assign timer_en_s  = (state_q == ST_ENTRY);
    // The idle timer restarts on every accepted key and whenever entry ends.
    assign timer_clr_s = key_acc_s | (state_d != ST_ENTRY);

    entry_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (timer_clr_s),
        .enable_i  (timer_en_s),
        .expired_o (timer_exp_s)
    );

    // Next-state and next-output logic for the entry FSM and digit array.
    always_comb begin
        state_d      = state_q;
        digits_d     = digits_q;
        count_d      = count_q;
        code_valid_d = code_valid_q;
        code_data_d  = code_data_q;
        entry_err_d  = 1'b0;
        timeout_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_ENTRY: begin
                if (key_acc_s) begin
                    if (bus.key_code <= KEY_DIGIT_MAX) begin
                        if (count_q < NUM_DIGITS) begin
                            digits_d[count_q] = bus.key_code;
                            count_d           = count_q + 3'd1;
                            state_d           = ST_ENTRY;
                        end else begin
                            count_d = count_q;
                        end
                    end else begin
                        case (bus.key_code)
                            KEY_BKSP: begin
                                if (count_q != 3'd0) begin
                                    digits_d[count_q - 3'd1] = DIGIT_BLANK;
                                    count_d = count_q - 3'd1;
                                    if (count_q == 3'd1) begin
                                        state_d = ST_IDLE;
                                    end else begin
                                        state_d = ST_ENTRY;
                                    end
                                end else begin
                                    count_d = count_q;
                                end
                            end
                            KEY_CLR: begin
                                digits_d = blank_digits();
                                count_d  = 3'd0;
                                state_d  = ST_IDLE;
                            end
                            KEY_ENTER: begin
                                if (count_q == NUM_DIGITS) begin
                                    code_data_d  = pack_code(digits_q);
                                    code_valid_d = 1'b1;
                                    state_d      = ST_PRESENT;
                                end else begin
                                    entry_err_d = 1'b1;
                                end
                            end
                            default: begin
                                state_d = state_q;
                            end
                        endcase
                    end
                end else if (timer_exp_s) begin
                    digits_d  = blank_digits();
                    count_d   = 3'd0;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_PRESENT: begin
                if (code_valid_q & bus.code_ready) begin
                    code_valid_d = 1'b0;
                    digits_d     = blank_digits();
                    count_d      = 3'd0;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_PRESENT;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                digits_d     = blank_digits();
                count_d      = 3'd0;
                code_valid_d = 1'b0;
            end
        endcase
        key_ready_d = (state_d != ST_PRESENT);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            digits_q     <= blank_digits();
            count_q      <= 3'd0;
            code_valid_q <= 1'b0;
            code_data_q  <= 24'h000000;
            key_ready_q  <= 1'b1;
            entry_err_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            digits_q     <= digits_d;
            count_q      <= count_d;
            code_valid_q <= code_valid_d;
            code_data_q  <= code_data_d;
            key_ready_q  <= key_ready_d;
            entry_err_q  <= entry_err_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.key_ready  = key_ready_q;
    assign bus.code_valid = code_valid_q;
    assign bus.code_data  = code_data_q;
    assign out1           = digits_q[0];
    assign out2           = digits_q[1];
    assign out3           = digits_q[2];
    assign out4           = digits_q[3];
    assign out5           = digits_q[4];
    assign out6           = digits_q[5];
    assign digit_count    = count_q;
    assign entry_err      = entry_err_q;
    assign timeout        = timeout_q;

endmodule

// File: tb/tb_key_entry_buffer.sv
// Bench for key_entry_buffer: directed scenarios plus random keypad traffic,
// every cycle compared against a queue-based model of the entry rules.
module tb_key_entry_buffer;

    localparam int TO = 20;

    logic       clk;
    logic       rst_n;
    logic [3:0] out1, out2, out3, out4, out5, out6;
    logic [2:0] digit_count;
    logic       entry_err;
    logic       timeout;

    key_entry_buffer_if bus();

    key_entry_buffer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .out1        (out1),
        .out2        (out2),
        .out3        (out3),
        .out4        (out4),
        .out5        (out5),
        .out6        (out6),
        .digit_count (digit_count),
        .entry_err   (entry_err),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int          m_dq[$];
    bit          m_pres;
    bit [23:0]   m_cdata;
    int          m_idle;
    bit          m_err;
    bit          m_to;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_dq.delete();
        m_pres  = 1'b0;
        m_cdata = 24'h000000;
        m_idle  = 0;
        m_err   = 1'b0;
        m_to    = 1'b0;
    endtask

    // One clock edge of the entry rules.
    task automatic model_step(input bit kv, input int kc, input bit cr);
        m_err = 1'b0;
        m_to  = 1'b0;
        if (m_pres) begin
            if (cr) begin
                m_pres = 1'b0;
                m_dq.delete();
            end
            m_idle = 0;
        end else if (kv) begin
            m_idle = 0;
            if (kc < 10) begin
                if (m_dq.size() < 6) m_dq.push_back(kc);
            end else if (kc == 10) begin
                if (m_dq.size() > 0) void'(m_dq.pop_back());
            end else if (kc == 11) begin
                if (m_dq.size() == 6) begin
                    m_cdata = 24'h000000;
                    foreach (m_dq[i]) m_cdata = (m_cdata << 4) | 24'(m_dq[i]);
                    m_pres = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end else if (kc == 12) begin
                m_dq.delete();
            end
        end else if (m_dq.size() > 0) begin
            if (m_idle == TO - 1) begin
                m_dq.delete();
                m_to   = 1'b1;
                m_idle = 0;
            end else begin
                m_idle++;
            end
        end else begin
            m_idle = 0;
        end
    endtask

    task automatic compare_all(input string ctx);
        logic [23:0] exp_d;
        exp_d = 24'h000000;
        for (int i = 0; i < 6; i++) begin
            exp_d = (exp_d << 4) | ((i < m_dq.size()) ? 24'(m_dq[i]) : 24'hF);
        end
        check_val({ctx, ".digits"}, 32'({out1, out2, out3, out4, out5, out6}), 32'(exp_d));
        check_val({ctx, ".count"}, 32'(digit_count), 32'(m_dq.size()));
        check_val({ctx, ".code_valid"}, 32'(bus.code_valid), 32'(m_pres));
        check_val({ctx, ".code_data"}, 32'(bus.code_data), 32'(m_cdata));
        check_val({ctx, ".key_ready"}, 32'(bus.key_ready), 32'(!m_pres));
        check_val({ctx, ".entry_err"}, 32'(entry_err), 32'(m_err));
        check_val({ctx, ".timeout"}, 32'(timeout), 32'(m_to));
    endtask

    task automatic step(input string ctx, input bit kv, input int kc, input bit cr);
        @(negedge clk);
        bus.key_valid  = kv;
        bus.key_code   = 4'(kc);
        bus.code_ready = cr;
        @(posedge clk);
        model_step(kv, kc, cr);
        #1;
        compare_all(ctx);
    endtask

    task automatic key(input string ctx, input int kc);
        step(ctx, 1'b1, kc, 1'b0);
    endtask

    task automatic idle(input string ctx, input int n);
        for (int i = 0; i < n; i++) step(ctx, 1'b0, 0, 1'b0);
    endtask

    initial begin
        bus.key_valid  = 1'b0;
        bus.key_code   = 4'h0;
        bus.code_ready = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        #3 compare_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Full code entry and presentation with delayed comparator.
        for (int d = 1; d <= 6; d++) key("load", d);
        key("enter", 11);
        idle("hold", 5);
        step("handshake", 1'b0, 0, 1'b1);
        idle("after_hs", 1);

        // Editing, short-entry error, seventh digit ignored.
        key("edit", 7);
        key("edit", 8);
        key("edit", 10);
        key("edit", 9);
        key("short_enter", 11);
        for (int d = 3; d <= 6; d++) key("fill", d);
        key("seventh", 1);
        key("clr6", 12);

        // Backspace at zero, clear at three.
        key("bksp0", 10);
        for (int d = 1; d <= 3; d++) key("pre_clr", d);
        key("clr3", 12);

        // Timeout exactly at the limit, and a key on the expiry cycle.
        key("to_key", 5);
        idle("to_wait", TO - 1);
        idle("to_fire", 1);
        key("to_key2", 5);
        idle("to_wait2", TO - 1);
        key("to_race", 6);
        idle("to_after", 2);
        key("clr", 12);

        // Asynchronous reset while a code is being offered.
        for (int d = 0; d <= 5; d++) key("rload", 9 - d);
        key("renter", 11);
        idle("rhold", 2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1 compare_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic with occasional long idle stretches.
        for (int n = 0; n < 3000; n++) begin
            int r;
            int kc;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                idle("rnd_gap", int'($urandom_range(15, 24)));
            end else begin
                if ($urandom_range(0, 9) < 6) kc = int'($urandom_range(0, 9));
                else kc = int'($urandom_range(10, 15));
                step("rnd", ($urandom_range(0, 9) < 6), kc, ($urandom_range(0, 3) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
